// File: rtl/move_sequencer.sv
// Move sequencer for a two-player 3x3 board game.
// Accepts a move request, presents a one-hot enable for one cycle, commits the
// move or rejects it, then pulses the result. Winner and game-over are decoded
// from the registered board.
module move_sequencer (
   input  logic       clock,
   input  logic       reset,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   input  logic       illegal_move,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   output logic [8:0] PL1_en,
   output logic [8:0] PL2_en,
   output logic       turn,
   output logic       move_ready,
   output logic       move_ok,
   output logic       move_reject,
   output logic [1:0] winner,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESULT, DONE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      pos_q, pos_d;
   logic [8:0][1:0] board_q, board_d;
   logic            turn_q, turn_d;
   logic [3:0]      count_q, count_d;
   logic            ok_q, ok_d;

   logic            in_range;
   logic [3:0]      sq_idx;
   logic            occupied;
   logic            p1_line, p2_line;

   assign in_range = (pos_q >= 4'd1) && (pos_q <= 4'd9);
   assign sq_idx   = pos_q - 4'd1;
   // Defence in depth: an occupied square is rejected even if the detector misses it.
   assign occupied = in_range && (board_q[sq_idx] != 2'b00);

   assign pos1 = board_q[0];
   assign pos2 = board_q[1];
   assign pos3 = board_q[2];
   assign pos4 = board_q[3];
   assign pos5 = board_q[4];
   assign pos6 = board_q[5];
   assign pos7 = board_q[6];
   assign pos8 = board_q[7];
   assign pos9 = board_q[8];
   assign turn = turn_q;

   function automatic logic line_of(input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] c, input logic [1:0] who);
      return (a == who) && (b == who) && (c == who);
   endfunction

   // Winner decode over the 3 rows, 3 columns and 2 diagonals.
   always_comb begin
      p1_line = 1'b0;
      p2_line = 1'b0;
      for (int unsigned w = 1; w <= 2; w++) begin
         logic hit;
         hit = line_of(board_q[0], board_q[1], board_q[2], 2'(w)) |
               line_of(board_q[3], board_q[4], board_q[5], 2'(w)) |
               line_of(board_q[6], board_q[7], board_q[8], 2'(w)) |
               line_of(board_q[0], board_q[3], board_q[6], 2'(w)) |
               line_of(board_q[1], board_q[4], board_q[7], 2'(w)) |
               line_of(board_q[2], board_q[5], board_q[8], 2'(w)) |
               line_of(board_q[0], board_q[4], board_q[8], 2'(w)) |
               line_of(board_q[2], board_q[4], board_q[6], 2'(w));
         if (w == 1) p1_line = hit;
         else        p2_line = hit;
      end
      if (p1_line)      winner = 2'b01;
      else if (p2_line) winner = 2'b10;
      else              winner = 2'b00;
      game_over = (winner != 2'b00) || (count_q == 4'd9);
   end

   // State and datapath registers; reset and new_game clear everything alike.
   always_ff @(posedge clock) begin
      if (reset || new_game) begin
         state_q <= IDLE;
         pos_q   <= '0;
         board_q <= '0;
         turn_q  <= 1'b0;
         count_q <= '0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         count_q <= count_d;
         ok_q    <= ok_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (game_over)       state_d = DONE;
                  else if (move_valid) state_d = ISSUE;
         ISSUE:   state_d = RESULT;
         RESULT:  state_d = IDLE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: latch the request, then commit or reject it at the end of ISSUE.
   always_comb begin
      pos_d   = pos_q;
      board_d = board_q;
      turn_d  = turn_q;
      count_d = count_q;
      ok_d    = ok_q;
      if (state_q == IDLE && !game_over && move_valid) begin
         pos_d = move_pos;
      end else if (state_q == ISSUE) begin
         if (!in_range || occupied || illegal_move) begin
            ok_d = 1'b0;
         end else begin
            board_d[sq_idx] = turn_q ? 2'b10 : 2'b01;
            turn_d          = ~turn_q;
            count_d         = (count_q == 4'd9) ? 4'd9 : count_q + 4'd1;
            ok_d            = 1'b1;
         end
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      move_ready  = (state_q == IDLE) && !game_over;
      PL1_en      = '0;
      PL2_en      = '0;
      move_ok     = (state_q == RESULT) && ok_q;
      move_reject = (state_q == RESULT) && !ok_q;
      if (state_q == ISSUE && in_range) begin
         if (turn_q) PL2_en = 9'(1) << sq_idx;
         else        PL1_en = 9'(1) << sq_idx;
      end
   end

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: a driver issues moves and pushes the
// expected outcome from a board model; a monitor checks each result pulse.
module tb_move_sequencer;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       new_game = 1'b0;
   logic       move_valid = 1'b0;
   logic [3:0] move_pos = '0;
   logic       illegal_move = 1'b0;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic [8:0] PL1_en, PL2_en;
   logic       turn, move_ready, move_ok, move_reject, game_over;
   logic [1:0] winner;

   move_sequencer dut (
      .clock(clock), .reset(reset), .new_game(new_game),
      .move_valid(move_valid), .move_pos(move_pos), .illegal_move(illegal_move),
      .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
      .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9),
      .PL1_en(PL1_en), .PL2_en(PL2_en), .turn(turn), .move_ready(move_ready),
      .move_ok(move_ok), .move_reject(move_reject), .winner(winner),
      .game_over(game_over)
   );

   always #5 clock = ~clock;

   int unsigned cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit          ok;
      logic [8:0]  en1;
      logic [8:0]  en2;
      logic [17:0] board;
      bit          trn;
      logic [1:0]  win;
      bit          gover;
      int unsigned cyc;
   } exp_t;

   exp_t       sb[$];
   logic [1:0] mb[1:9];
   bit         mturn;
   int         mcount;

   int lines[8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

   function automatic void model_clear();
      for (int k = 1; k <= 9; k++) mb[k] = 2'b00;
      mturn  = 1'b0;
      mcount = 0;
   endfunction

   function automatic logic [17:0] model_board();
      logic [17:0] r;
      r = '0;
      for (int k = 1; k <= 9; k++) r[2*(k-1) +: 2] = mb[k];
      return r;
   endfunction

   function automatic logic [1:0] model_winner();
      for (int w = 1; w <= 2; w++)
         for (int l = 0; l < 8; l++)
            if (mb[lines[l][0]] == 2'(w) && mb[lines[l][1]] == 2'(w) && mb[lines[l][2]] == 2'(w))
               return 2'(w);
      return 2'b00;
   endfunction

   function automatic bit model_over();
      return (model_winner() != 2'b00) || (mcount == 9);
   endfunction

   wire [17:0] board_out = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

   // ---------------- monitor ----------------
   logic [8:0] prev1 = '0;
   logic [8:0] prev2 = '0;
   exp_t       me;

   always @(negedge clock) begin
      if (move_ok || move_reject) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {move_ok, move_reject}, 2'b00);
         end else begin
            me = sb.pop_front();
            check("result", {move_ok, move_reject}, me.ok ? 2'b10 : 2'b01);
            check("pulse_cycle", cyc, me.cyc);
            check("PL1_en_issue", prev1, me.en1);
            check("PL2_en_issue", prev2, me.en2);
            check("board", board_out, me.board);
            check("turn", turn, me.trn);
            check("winner", winner, me.win);
            check("game_over", game_over, me.gover);
         end
      end
      check("en_onehot", {$onehot0(PL1_en), $onehot0(PL2_en), (PL1_en == 0 || PL2_en == 0)}, 3'b111);
      prev1 = PL1_en;
      prev2 = PL2_en;
   end

   // ---------------- driver ----------------
   // abort: 0 none, 1 reset during ISSUE, 2 new_game during ISSUE
   task automatic issue(input logic [3:0] p, input bit force_ill, input int abort);
      int unsigned c;
      int          k;
      bit          inr, occ;
      exp_t        e;
      @(negedge clock);
      k = 0;
      while (!move_ready && k < 20) begin
         @(negedge clock);
         k++;
      end
      if (!move_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      move_valid = 1'b1;
      move_pos   = p;
      c          = cyc;
      @(posedge clock);
      #1;
      move_valid = 1'b0;
      move_pos   = 4'($urandom_range(0, 15));
      inr = (p >= 4'd1) && (p <= 4'd9);
      occ = 1'b0;
      if (inr) occ = (mb[p] != 2'b00);
      illegal_move = force_ill || occ;
      e.en1 = (inr && !mturn) ? (9'(1) << (p - 4'd1)) : 9'h000;
      e.en2 = (inr &&  mturn) ? (9'(1) << (p - 4'd1)) : 9'h000;
      if (abort == 1) reset = 1'b1;
      if (abort == 2) new_game = 1'b1;
      if (abort == 0) begin
         e.ok = inr && !illegal_move;
         if (e.ok) begin
            mb[p]  = mturn ? 2'b10 : 2'b01;
            mturn  = !mturn;
            mcount = mcount + 1;
         end
         e.board = model_board();
         e.trn   = mturn;
         e.win   = model_winner();
         e.gover = model_over();
         e.cyc   = c + 2;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      illegal_move = 1'b0;
      reset        = 1'b0;
      new_game     = 1'b0;
      if (abort != 0) model_clear();
   endtask

   task automatic check_reset_state(input string tag);
      @(negedge clock);
      check({tag, "_board"}, board_out, 18'h0);
      check({tag, "_turn"}, turn, 1'b0);
      check({tag, "_winner"}, winner, 2'b00);
      check({tag, "_game_over"}, game_over, 1'b0);
      check({tag, "_ready"}, move_ready, 1'b1);
      check({tag, "_en"}, {PL1_en, PL2_en}, 18'h0);
      check({tag, "_pulses"}, {move_ok, move_reject}, 2'b00);
   endtask

   task automatic clear_game();
      @(negedge clock);
      new_game = 1'b1;
      @(posedge clock);
      #1 new_game = 1'b0;
      model_clear();
   endtask

   task automatic check_done(input string tag);
      repeat (2) @(negedge clock);
      check({tag, "_ready_low"}, move_ready, 1'b0);
      check({tag, "_game_over"}, game_over, 1'b1);
      check({tag, "_winner"}, winner, model_winner());
      for (int i = 0; i < 4; i++) begin
         move_valid = 1'b1;
         move_pos   = 4'($urandom_range(1, 9));
         @(negedge clock);
         check({tag, "_ready_stays_low"}, move_ready, 1'b0);
      end
      move_valid = 1'b0;
      repeat (3) @(negedge clock);
      check({tag, "_board_frozen"}, board_out, model_board());
      check({tag, "_en_zero"}, {PL1_en, PL2_en}, 18'h0);
   endtask

   int draw_seq[9] = '{1, 5, 3, 2, 8, 7, 4, 6, 9};
   int win_seq[5]  = '{1, 2, 5, 3, 9};

   initial begin
      model_clear();
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check_reset_state("reset");

      // P1 takes square 1; P2 then tries square 1 against the detector
      issue(4'd1, 1'b0, 0);
      issue(4'd1, 1'b1, 0);
      // out-of-range squares
      issue(4'd0, 1'b0, 0);
      issue(4'd12, 1'b1, 0);

      // aborts during ISSUE
      issue(4'd5, 1'b0, 1);
      check_reset_state("abort_reset");
      issue(4'd7, 1'b0, 2);
      check_reset_state("abort_new_game");

      // P1 wins on the diagonal 1-5-9
      clear_game();
      foreach (win_seq[i]) issue(4'(win_seq[i]), 1'b0, 0);
      check_done("p1_win");
      check("p1_win_value", winner, 2'b01);

      // full board with no line
      clear_game();
      foreach (draw_seq[i]) issue(4'(draw_seq[i]), 1'b0, 0);
      check_done("draw");
      check("draw_winner", winner, 2'b00);

      // random games
      for (int g = 0; g < 5; g++) begin
         clear_game();
         for (int a = 0; a < 60 && !model_over(); a++) begin
            logic [3:0] p;
            if ($urandom_range(0, 3) == 0) p = 4'($urandom_range(0, 15));
            else                           p = 4'($urandom_range(1, 9));
            issue(p, $urandom_range(0, 9) == 0, 0);
         end
         if (model_over()) check_done("rand_game");
      end

      repeat (5) @(negedge clock);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish by %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  reset, synchronous, active-high; sampled only on rising clock edge.
REQ-003 SHALL have port: new_game  input  1  synchronous clear of board/turn/count, same effect as reset, lower priority than reset.
REQ-004 SHALL have port: move_valid  input  1  move request from the current player, qualified by move_ready.
REQ-005 SHALL have port: move_pos  input  4  requested square; 1..9 legal encodings, 0 and 10..15 out of range.
REQ-006 SHALL have port: illegal_move  input  1  combinational verdict from the illegal-move detector on the current pos1..pos9 / PL1_en / PL2_en.
REQ-007 SHALL have ports: pos1..pos9  output  2 each  board squares; 00 empty, 01 player 1, 10 player 2, 11 never driven.
REQ-008 SHALL have ports: PL1_en, PL2_en  output  9 each  one-hot square enables; bit k-1 = square k.
REQ-009 SHALL have port: turn  output  1  0 = player 1 to move, 1 = player 2 to move.
REQ-010 SHALL have port: move_ready  output  1  high when a request is accepted this cycle.
REQ-011 SHALL have ports: move_ok, move_reject  output  1 each  one-cycle result pulses.
REQ-012 SHALL have port: winner  output  2  00 none, 01 player 1, 10 player 2.
REQ-013 SHALL have port: game_over  output  1  high when winner != 00 or move_count == 9.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, ISSUE, RESULT, DONE.
REQ-015 IDLE: move_ready = !game_over; on move_valid && move_ready, latch move_pos and go to ISSUE (edge N).
REQ-016 IDLE with game_over high SHALL go to DONE on the next edge; move_valid is ignored.
REQ-017 ISSUE (cycle N+1): for an in-range move_pos, exactly one bit of the current player's enable is high; the other player's enable is 0.
REQ-018 ISSUE with out-of-range move_pos: both enables SHALL stay 0, and the move SHALL be rejected without sampling illegal_move.
REQ-019 End of ISSUE: if illegal_move = 1 or move_pos is out of range, the board, turn and count SHALL stay unchanged and the block SHALL go to RESULT with reject.
REQ-020 End of ISSUE, otherwise: write 01 (turn=0) or 10 (turn=1) into the addressed square, toggle turn, increment move_count, then go to RESULT with ok.
REQ-021 RESULT (cycle N+2): pulse exactly one of move_ok / move_reject for one cycle; enables 0; then go to IDLE.
REQ-022 Minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-023 move_count SHALL be 4 bits and saturate at 9; no wrap.
REQ-024 winner SHALL decode the 8 lines (3 rows, 3 columns, 2 diagonals) from the registered board; a three-in-a-row of 01 gives 01, of 10 gives 10.
REQ-025 DONE: board frozen, move_ready 0, enables 0, pulses 0; exit only via reset or new_game.
REQ-026 A square that holds a nonzero value SHALL never be overwritten by the block.
REQ-027 PL1_en and PL2_en SHALL be 0 in every state except ISSUE.

Reset
REQ-028 On reset or new_game: state IDLE, all pos* 00, turn 0, move_count 0, enables 0, move_ok/move_reject 0, winner 00, game_over 0.
REQ-029 Reset or new_game asserted in ISSUE or RESULT SHALL abort the move: no board write, no result pulse on the following cycle.
REQ-030 When reset and new_game are both high, the reset behaviour SHALL apply; both have identical effect.

Verification
REQ-031 The bench SHALL cover: after reset, move_pos=1 with illegal_move tied 0 -> PL1_en=9'h001 in cycle N+1, pos1=01, move_ok pulse at N+2, turn=1.
REQ-032 The bench SHALL cover: player 2 requests square 1 while the detector drives illegal_move=1 during ISSUE -> move_reject pulse, pos1 stays 01, turn stays 1.
REQ-033 The bench SHALL cover: move_pos=0 and move_pos=12 -> both enables 0 throughout, move_reject pulse, board unchanged.
REQ-034 The bench SHALL cover: P1 plays 1, 5, 9 interleaved with P2 playing 2, 3 -> winner=01, game_over=1, DONE state, further move_valid ignored with move_ready 0.
REQ-035 The bench SHALL cover: nine legal alternating moves with no line formed -> move_count=9, winner=00, game_over=1.
REQ-036 The bench SHALL cover: reset asserted during ISSUE of a legal move -> no board write, no move_ok pulse, all outputs at reset values.
